gshare_ckpt: RTL and testbench

Parametrised gshare direction predictor with a speculative global history register (GHR), checkpoint-based history recovery, a multi-cycle PHT initialisation sweep and performance counters. It sits beside the fetch/decode front end: ID issues predictions and EX resolves them. The GHR is shifted speculatively at predict time. On a mispredict it is rebuilt from the checkpoint carried down the pipeline, which closes the stale-history hazard of the earlier single-register predictor.

---
 rtl/gshare_ckpt.sv | 79 +++++++
 tb/tb_gshare_ckpt.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gshare_ckpt.sv
// gshare_ckpt: gshare direction predictor with speculative GHR, checkpoint recovery,
// PHT init sweep and branch/mispredict counters.
module gshare_ckpt #(
  parameter int GHR_LEN  = 8,
  parameter int PHT_IDX  = 8,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                init_done,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [PHT_IDX-1:0]  pred_index,
  output logic [GHR_LEN-1:0]  pred_ghr,
  input  logic                res_valid,
  input  logic [PHT_IDX-1:0]  res_index,
  input  logic [GHR_LEN-1:0]  res_ghr,
  input  logic                res_taken,
  input  logic                res_mispredict,
  output logic [GHR_LEN-1:0]  ghr,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispred
);
  localparam int PHT_SIZE = 1 << PHT_IDX;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  typedef enum logic {INIT, READY} state_t;

  state_t              state;
  logic [PHT_IDX-1:0]  sweep_cnt;
  logic [CTR_BITS-1:0] pht [PHT_SIZE];
  logic [CTR_BITS-1:0] res_ctr, res_upd, pred_ctr;
  logic                ready, res_fire, recover;
  logic                unused;

  assign ready      = state == READY;
  assign init_done  = ready;
  assign res_fire   = ready & res_valid;
  assign recover    = res_fire & res_mispredict;
  assign pred_ghr   = ghr;
  assign pred_index = pred_pc[PHT_IDX+1:2] ^ PHT_IDX'(ghr);
  assign unused     = ^{pred_pc[31:PHT_IDX+2], pred_pc[1:0], res_ghr[GHR_LEN-1]};

  // Same-cycle resolve to the predicted entry forwards the updated counter.
  always_comb begin
    res_ctr    = pht[res_index];
    res_upd    = res_taken ? (res_ctr == CTR_MAX ? res_ctr : res_ctr + 1'b1)
                           : (res_ctr == '0 ? res_ctr : res_ctr - 1'b1);
    pred_ctr   = (res_fire && res_index == pred_index) ? res_upd : pht[pred_index];
    pred_taken = ready & pred_ctr[CTR_BITS-1];
  end

  always_ff @(posedge clk) begin
    if (!ready) pht[sweep_cnt] <= CTR_INIT;
    else if (res_valid) pht[res_index] <= res_upd;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= INIT;
      sweep_cnt     <= '0;
      ghr           <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (!ready) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (&sweep_cnt) state <= READY;
    end else begin
      if (recover) ghr <= {res_ghr[GHR_LEN-2:0], res_taken};
      else if (pred_valid) ghr <= {ghr[GHR_LEN-2:0], pred_taken};
      if (res_valid) begin
        stat_branches <= stat_branches + 1'b1;
        if (res_mispredict) stat_mispred <= stat_mispred + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gshare_ckpt.sv
// tb_gshare_ckpt: directed table-driven checks of gshare_ckpt at default parameters.
module tb_gshare_ckpt;
  logic        clk = 0;
  logic        resetn = 0;
  logic        init_done;
  logic        pred_valid = 0;
  logic [31:0] pred_pc = 0;
  logic        pred_taken;
  logic [7:0]  pred_index;
  logic [7:0]  pred_ghr;
  logic        res_valid = 0;
  logic [7:0]  res_index = 0;
  logic [7:0]  res_ghr = 0;
  logic        res_taken = 0;
  logic        res_mispredict = 0;
  logic [7:0]  ghr;
  logic [31:0] stat_branches, stat_mispred;

  int total = 0;
  int passed = 0;

  gshare_ckpt dut (
    .clk(clk), .resetn(resetn), .init_done(init_done),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_index(pred_index), .pred_ghr(pred_ghr),
    .res_valid(res_valid), .res_index(res_index), .res_ghr(res_ghr),
    .res_taken(res_taken), .res_mispredict(res_mispredict),
    .ghr(ghr), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        rv;
    logic [7:0]  ri;
    logic [7:0]  rg;
    logic        rt;
    logic        rm;
    logic        et;
    logic [7:0]  ei;
    logic [7:0]  eg;
  } vec_t;

  vec_t v[21];

  function automatic vec_t mk(logic pv, logic [31:0] pc, logic rv, logic [7:0] ri,
                              logic [7:0] rg, logic rt, logic rm, logic et,
                              logic [7:0] ei, logic [7:0] eg);
    vec_t r;
    r.pv = pv; r.pc = pc; r.rv = rv; r.ri = ri; r.rg = rg;
    r.rt = rt; r.rm = rm; r.et = et; r.ei = ei; r.eg = eg;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid = 0; pred_pc = 0; res_valid = 0; res_index = 0;
    res_ghr = 0; res_taken = 0; res_mispredict = 0;
  endtask

  // Counts 256 edges after release; init_done must be low for 255 and high on the 256th.
  task automatic sweep(input string tag, input bit noise);
    int early = 0;
    int taken_bad = 0;
    if (noise) begin
      pred_valid = 1; pred_pc = 32'h10;
      res_valid = 1; res_index = 8'h04; res_taken = 0; res_mispredict = 1; res_ghr = 8'h55;
    end
    for (int i = 1; i <= 256; i++) begin
      #1;
      if (pred_taken !== 1'b0) taken_bad++;
      tick();
      if (i < 256 && init_done !== 1'b0) early++;
    end
    chk({tag, "_init_low"}, early, 0);
    chk({tag, "_init_high"}, {31'b0, init_done}, 1);
    if (noise) chk({tag, "_init_taken"}, taken_bad, 0);
    idle();
    #1;
    chk({tag, "_ghr_after_init"}, ghr, 0);
    chk({tag, "_br_after_init"}, stat_branches, 0);
    chk({tag, "_mp_after_init"}, stat_mispred, 0);
  endtask

  initial begin
    logic [7:0] prev_ghr;
    v[0]  = mk(0, 32'h14, 0, 8'h00, 8'h00, 0, 0, 1, 8'h05, 8'h00);
    v[1]  = mk(0, 32'h14, 1, 8'h05, 8'h00, 1, 0, 1, 8'h05, 8'h00);
    v[2]  = mk(0, 32'h14, 1, 8'h05, 8'h00, 1, 0, 1, 8'h05, 8'h00);
    v[3]  = mk(0, 32'h14, 1, 8'h05, 8'h00, 1, 0, 1, 8'h05, 8'h00);
    v[4]  = mk(0, 32'h14, 1, 8'h05, 8'h00, 1, 0, 1, 8'h05, 8'h00);
    v[5]  = mk(0, 32'h14, 1, 8'h05, 8'h00, 0, 0, 1, 8'h05, 8'h00);
    v[6]  = mk(0, 32'h14, 1, 8'h05, 8'h00, 0, 0, 0, 8'h05, 8'h00);
    v[7]  = mk(0, 32'h14, 1, 8'h05, 8'h00, 0, 0, 0, 8'h05, 8'h00);
    v[8]  = mk(0, 32'h14, 1, 8'h05, 8'h00, 0, 0, 0, 8'h05, 8'h00);
    v[9]  = mk(0, 32'h14, 1, 8'h05, 8'h00, 0, 0, 0, 8'h05, 8'h00);
    v[10] = mk(0, 32'h14, 1, 8'h05, 8'h00, 1, 0, 0, 8'h05, 8'h00);
    v[11] = mk(0, 32'h14, 1, 8'h05, 8'h00, 1, 0, 1, 8'h05, 8'h00);
    v[12] = mk(1, 32'h10, 0, 8'h00, 8'h00, 0, 0, 1, 8'h04, 8'h01);
    v[13] = mk(1, 32'h10, 0, 8'h00, 8'h00, 0, 0, 1, 8'h05, 8'h03);
    v[14] = mk(1, 32'h10, 0, 8'h00, 8'h00, 0, 0, 1, 8'h07, 8'h07);
    v[15] = mk(0, 32'h00, 1, 8'h20, 8'h01, 0, 1, 1, 8'h07, 8'h02);
    v[16] = mk(1, 32'h10, 1, 8'h21, 8'h10, 1, 1, 1, 8'h06, 8'h21);
    v[17] = mk(0, 32'h00, 1, 8'h07, 8'h00, 0, 0, 1, 8'h21, 8'h21);
    v[18] = mk(0, 32'h98, 0, 8'h00, 8'h00, 0, 0, 0, 8'h07, 8'h21);
    v[19] = mk(1, 32'h98, 1, 8'h07, 8'h00, 1, 0, 1, 8'h07, 8'h43);
    v[20] = mk(0, 32'h110, 0, 8'h00, 8'h00, 0, 0, 1, 8'h07, 8'h43);

    idle();
    pred_pc = 32'h00400010;
    tick(); tick();
    chk("rst_init_done", {31'b0, init_done}, 0);
    chk("rst_ghr", ghr, 0);
    chk("rst_branches", stat_branches, 0);
    chk("rst_mispred", stat_mispred, 0);
    chk("rst_taken", {31'b0, pred_taken}, 0);
    chk("rst_index", pred_index, 8'h04);
    chk("rst_pred_ghr", pred_ghr, 0);
    pred_pc = 0;
    resetn = 1;
    sweep("pwr", 1);

    pred_pc = 32'h00400010;
    #1;
    chk("first_index", pred_index, 8'h04);
    chk("first_taken", {31'b0, pred_taken}, 1);

    prev_ghr = 8'h00;
    for (int i = 0; i < 21; i++) begin
      pred_valid = v[i].pv; pred_pc = v[i].pc; res_valid = v[i].rv;
      res_index = v[i].ri; res_ghr = v[i].rg; res_taken = v[i].rt;
      res_mispredict = v[i].rm;
      #1;
      chk($sformatf("v%0d_taken", i), {31'b0, pred_taken}, {31'b0, v[i].et});
      chk($sformatf("v%0d_index", i), pred_index, v[i].ei);
      chk($sformatf("v%0d_pred_ghr", i), pred_ghr, prev_ghr);
      tick();
      chk($sformatf("v%0d_ghr", i), ghr, v[i].eg);
      prev_ghr = v[i].eg;
    end
    idle();
    #1;
    chk("stat_branches", stat_branches, 15);
    chk("stat_mispred", stat_mispred, 2);

    resetn = 0;
    tick();
    chk("live_rst_ghr", ghr, 0);
    chk("live_rst_branches", stat_branches, 0);
    chk("live_rst_mispred", stat_mispred, 0);
    chk("live_rst_init_done", {31'b0, init_done}, 0);
    resetn = 1;
    for (int i = 0; i < 100; i++) tick();
    resetn = 0;
    tick();
    chk("mid_rst_init_done", {31'b0, init_done}, 0);
    chk("mid_rst_ghr", ghr, 0);
    resetn = 1;
    sweep("mid", 0);

    pred_pc = 32'h80;
    #1;
    chk("reinit_idx20_taken", {31'b0, pred_taken}, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
